// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester arbiter for the shared Y86 ALU with a 1-deep response buffer and ZF/SF/OF register
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_setcc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_setcc,
  output logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic last_grant, any, gnt, acc, sel_setcc;
  assign rsp_valid = state == FULL;
  always_comb begin
    any = req0_valid | req1_valid;
    gnt = (req0_valid & req1_valid) ? (RR_EN ? ~last_grant : 1'b0) : req1_valid;
    acc = rst_n & any & (state == EMPTY | rsp_ready);
    req0_ready = acc & ~gnt;
    req1_ready = acc & gnt;
    alu_control = ~any ? 2'b00 : gnt ? req1_fun : req0_fun;
    alu_a = ~any ? '0 : gnt ? req1_a : req0_a;
    alu_b = ~any ? '0 : gnt ? req1_b : req0_b;
    sel_setcc = gnt ? req1_setcc : req0_setcc;
    state_nx = acc ? FULL : rsp_ready ? EMPTY : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_overflow <= 1'b0;
      last_grant <= 1'b1;
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else begin
      if (acc) begin
        rsp_id <= gnt;
        rsp_result <= alu_y;
        rsp_overflow <= alu_overflow;
        last_grant <= gnt;
      end
      if (acc & sel_setcc) begin
        cc_zf <= alu_y == '0;
        cc_sf <= alu_y[WIDTH-1];
        cc_of <= alu_overflow;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vector bench for alu_share_arbiter in round-robin and fixed-priority builds
module tb_alu_share_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic v0, v1, s0, s1, rdy;
  logic [1:0] f0, f1;
  logic [63:0] a0, b0, a1, b1;
  logic r0_r, r1_r, rv_r, id_r, ov_r, zf_r, sf_r, of_r, aov_r;
  logic r0_f, r1_f, rv_f, id_f, ov_f, zf_f, sf_f, of_f, aov_f;
  logic [1:0] ctl_r, ctl_f;
  logic [63:0] aa_r, ab_r, ay_r, res_r, aa_f, ab_f, ay_f, res_f;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [64:0] alu(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] y;
    logic ov;
    y = f == 2'd0 ? a + b : f == 2'd1 ? a - b : f == 2'd2 ? a & b : a ^ b;
    ov = f == 2'd0 ? (a[63] == b[63] && y[63] != a[63]) : f == 2'd1 ? (a[63] != b[63] && y[63] != a[63]) : 1'b0;
    return {ov, y};
  endfunction
  assign {aov_r, ay_r} = alu(ctl_r, aa_r, ab_r);
  assign {aov_f, ay_f} = alu(ctl_f, aa_f, ab_f);
  alu_share_arbiter #(.WIDTH(64), .RR_EN(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0_r), .req0_fun(f0), .req0_a(a0), .req0_b(b0), .req0_setcc(s0),
    .req1_valid(v1), .req1_ready(r1_r), .req1_fun(f1), .req1_a(a1), .req1_b(b1), .req1_setcc(s1),
    .alu_control(ctl_r), .alu_a(aa_r), .alu_b(ab_r), .alu_y(ay_r), .alu_overflow(aov_r),
    .rsp_valid(rv_r), .rsp_ready(rdy), .rsp_id(id_r), .rsp_result(res_r), .rsp_overflow(ov_r),
    .cc_zf(zf_r), .cc_sf(sf_r), .cc_of(of_r));
  alu_share_arbiter #(.WIDTH(64), .RR_EN(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0_f), .req0_fun(f0), .req0_a(a0), .req0_b(b0), .req0_setcc(s0),
    .req1_valid(v1), .req1_ready(r1_f), .req1_fun(f1), .req1_a(a1), .req1_b(b1), .req1_setcc(s1),
    .alu_control(ctl_f), .alu_a(aa_f), .alu_b(ab_f), .alu_y(ay_f), .alu_overflow(aov_f),
    .rsp_valid(rv_f), .rsp_ready(rdy), .rsp_id(id_f), .rsp_result(res_f), .rsp_overflow(ov_f),
    .cc_zf(zf_f), .cc_sf(sf_f), .cc_of(of_f));
  typedef struct {
    logic v0; logic [1:0] f0; logic [63:0] a0, b0; logic s0;
    logic v1; logic [1:0] f1; logic [63:0] a1, b1; logic s1;
    logic rdy;
    logic er0, er1, erv, eid; logic [63:0] eres; logic eov; logic [2:0] ecc;
    logic efid;
  } vec_t;
  vec_t vt[13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    v0 = t.v0; f0 = t.f0; a0 = t.a0; b0 = t.b0; s0 = t.s0;
    v1 = t.v1; f1 = t.f1; a1 = t.a1; b1 = t.b1; s1 = t.s1;
    rdy = t.rdy;
  endtask
  task automatic chk_rsp(input string nm, input logic rv, input logic id, input logic [63:0] res, input logic [2:0] cc);
    chk({nm, "_rsp_valid"}, 64'(rv_r), 64'(rv));
    chk({nm, "_rsp_id"}, 64'(id_r), 64'(id));
    chk({nm, "_rsp_result"}, res_r, res);
    chk({nm, "_cc"}, 64'({zf_r, sf_r, of_r}), 64'(cc));
  endtask
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MN = 64'h8000_0000_0000_0000;
  initial begin
    vt[0]  = '{1'b1, 2'd0, M1, 64'd1, 1'b1, 1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 3'b100, 1'b0};
    vt[1]  = '{1'b1, 2'd0, MX, 64'd1, 1'b1, 1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, MN, 1'b1, 3'b011, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, 2'd1, 64'd5, 64'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'd3, 1'b0, 3'b011, 1'b1};
    for (int i = 0; i < 6; i++)
      vt[3+i] = '{1'b1, 2'd0, 64'd10, 64'd1, 1'b0, 1'b1, 2'd2, 64'hF0, 64'h3C, 1'b0, 1'b1,
                  ~i[0], i[0], 1'b1, i[0], i[0] ? 64'h30 : 64'd11, 1'b0, 3'b011, 1'b0};
    for (int i = 0; i < 3; i++)
      vt[9+i] = '{1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, 2'd2, 64'd8, M1, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b1, 64'h30, 1'b0, 3'b011, 1'b0};
    vt[12] = '{1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, 2'd2, 64'd8, M1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'd8, 1'b0, 3'b011, 1'b1};
    v0 = 1'b1; f0 = 2'd0; a0 = 64'd0; b0 = 64'd0; s0 = 1'b0;
    v1 = 1'b1; f1 = 2'd0; a1 = 64'd0; b1 = 64'd0; s1 = 1'b0; rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ready0", 64'(r0_r), 64'd0);
    chk("reset_ready1", 64'(r1_r), 64'd0);
    chk_rsp("reset", 1'b0, 1'b0, 64'd0, 3'b100);
    chk("reset_rsp_overflow", 64'(ov_r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d_req0_ready", i), 64'(r0_r), 64'(vt[i].er0));
      chk($sformatf("v%0d_req1_ready", i), 64'(r1_r), 64'(vt[i].er1));
      @(posedge clk);
      #1;
      chk_rsp($sformatf("v%0d", i), vt[i].erv, vt[i].eid, vt[i].eres, vt[i].ecc);
      chk($sformatf("v%0d_rsp_overflow", i), 64'(ov_r), 64'(vt[i].eov));
      chk($sformatf("v%0d_fp_rsp_valid", i), 64'(rv_f), 64'(vt[i].erv));
      chk($sformatf("v%0d_fp_rsp_id", i), 64'(id_f), 64'(vt[i].efid));
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0; f1 = 2'd3; a1 = 64'd7; b1 = 64'd9; rdy = 1'b1;
    #1;
    chk("idle_alu_control", 64'(ctl_r), 64'd0);
    chk("idle_alu_a", aa_r, 64'd0);
    chk("idle_alu_b", ab_r, 64'd0);
    @(posedge clk);
    #1;
    chk_rsp("idle", 1'b0, 1'b1, 64'd8, 3'b011);
    @(negedge clk);
    v0 = 1'b1; f0 = 2'd0; a0 = MX; b0 = 64'd1; s0 = 1'b1;
    @(posedge clk);
    #1;
    chk_rsp("pre_areset", 1'b1, 1'b0, MN, 3'b011);
    #1 rst_n = 1'b0;
    #1;
    chk_rsp("areset", 1'b0, 1'b0, 64'd0, 3'b100);
    chk("areset_req0_ready", 64'(r0_r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a0 = M1; b0 = 64'd1;
    #1;
    chk("post_reset_req0_ready", 64'(r0_r), 64'd1);
    @(posedge clk);
    #1;
    chk_rsp("post_reset", 1'b1, 1'b0, 64'd0, 3'b100);
    chk("post_reset_rsp_overflow", 64'(ov_r), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
